// File: rtl/boot_rom_loader_pkg.sv
// Shared configuration for the boot-time flash-to-SDRAM copier: region map
// defaults, the region descriptor type and the loader state encoding.
package boot_rom_loader_pkg;

  localparam int ADDR_W = 24;

  localparam int ENABLE_NEXTOR  = 1;
  localparam int ENABLE_FM      = 1;
  localparam int ENABLE_MEGAROM = 1;

  localparam logic [ADDR_W-1:0] FLASH_ADDR_BIOS    = 24'h10_0000;
  localparam logic [ADDR_W-1:0] RAM_ADDR_BIOS      = 24'h70_0000;
  localparam logic [ADDR_W-1:0] FLASH_SIZE_BIOS    = 24'h02_4000;
  localparam logic [ADDR_W-1:0] FLASH_ADDR_MEGAROM = 24'h20_0000;
  localparam logic [ADDR_W-1:0] RAM_ADDR_MEGAROM   = 24'h40_0000;
  localparam logic [ADDR_W-1:0] FLASH_SIZE_MEGAROM = 24'h20_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] size;
    logic              enable;
  } region_t;

  typedef enum logic [2:0] {
    LD_SEL,
    LD_START,
    LD_STREAM,
    LD_FLUSH,
    LD_STOP,
    LD_FIN
  } loader_state_t;

  // A region with zero size is treated the same as a disabled one.
  function automatic region_t make_region(logic [ADDR_W-1:0] src,
                                          logic [ADDR_W-1:0] dst,
                                          logic [ADDR_W-1:0] size,
                                          logic              en);
    region_t r;
    r.src    = src;
    r.dst    = dst;
    r.size   = size;
    r.enable = en && (size != '0);
    return r;
  endfunction

endpackage

// File: rtl/boot_rom_loader_if.sv
// Flash read stream and SDRAM word-write port used by the boot loader.
interface boot_rom_loader_if;
  import boot_rom_loader_pkg::*;

  logic              FLASH_START;
  logic [ADDR_W-1:0] FLASH_ADDR;
  logic              FLASH_STOP;
  logic              FLASH_VALID;
  logic [7:0]        FLASH_DATA;
  logic              FLASH_READY;
  logic              RAM_WR_REQ;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [15:0]       RAM_WDATA;
  logic              RAM_ACK;

  modport master (
    output FLASH_START, FLASH_ADDR, FLASH_STOP, FLASH_READY,
    output RAM_WR_REQ, RAM_ADDR, RAM_WDATA,
    input  FLASH_VALID, FLASH_DATA, RAM_ACK
  );

  modport slave (
    input  FLASH_START, FLASH_ADDR, FLASH_STOP, FLASH_READY,
    input  RAM_WR_REQ, RAM_ADDR, RAM_WDATA,
    output FLASH_VALID, FLASH_DATA, RAM_ACK
  );
endinterface

// File: rtl/boot_rom_loader_byte_to_word_packer.sv
// Pairs consecutive flash bytes into little-endian 16-bit words and holds
// the SDRAM write request until it is acknowledged.
module byte_to_word_packer
  import boot_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_odd_i,
  input  logic [ADDR_W-1:0] word_addr_i,
  input  logic              ack_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       data_o
);

  logic [7:0]        low_q, low_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;

  // Capture even bytes, form a word on odd bytes, drop the request on ack.
  always_comb begin
    low_d  = low_q;
    req_d  = req_q;
    addr_d = addr_q;
    data_d = data_q;
    if (req_q && ack_i) begin
      req_d = 1'b0;
    end
    if (byte_valid_i) begin
      if (!byte_odd_i) begin
        low_d = byte_i;
      end else begin
        req_d  = 1'b1;
        addr_d = word_addr_i;
        data_d = {byte_i, low_q};
      end
    end
  end

  // Request handshake and the visible word/address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Low-byte holding register carries no control meaning, so it is not reset.
  always_ff @(posedge clk) begin
    low_q <= low_d;
  end

  assign req_o  = req_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/boot_rom_loader.sv
// Copies the BIOS and MegaROM images from SPI flash into SDRAM after reset,
// holding BUSY until every enabled region has been written.
module boot_rom_loader
  import boot_rom_loader_pkg::*;
#(
  parameter bit                COPY_BIOS    = (ENABLE_NEXTOR != 0) || (ENABLE_FM != 0),
  parameter bit                COPY_MEGAROM = (ENABLE_MEGAROM != 0),
  parameter logic [ADDR_W-1:0] BIOS_SRC     = FLASH_ADDR_BIOS,
  parameter logic [ADDR_W-1:0] BIOS_DST     = RAM_ADDR_BIOS,
  parameter logic [ADDR_W-1:0] BIOS_SIZE    = FLASH_SIZE_BIOS,
  parameter logic [ADDR_W-1:0] MEGA_SRC     = FLASH_ADDR_MEGAROM,
  parameter logic [ADDR_W-1:0] MEGA_DST     = RAM_ADDR_MEGAROM,
  parameter logic [ADDR_W-1:0] MEGA_SIZE    = FLASH_SIZE_MEGAROM
) (
  input  logic               CLK,
  input  logic               RESET,
  boot_rom_loader_if.master  bus,
  output logic               BUSY,
  output logic               DONE
);

  localparam region_t REGION0 = make_region(BIOS_SRC, BIOS_DST, BIOS_SIZE, COPY_BIOS);
  localparam region_t REGION1 = make_region(MEGA_SRC, MEGA_DST, MEGA_SIZE, COPY_MEGAROM);

  loader_state_t     state_q, state_d;
  logic [1:0]        next_idx_q, next_idx_d;
  region_t           cur_q, cur_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
  logic              flash_start_q, flash_start_d;
  logic              flash_stop_q, flash_stop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              ready;
  logic              accept;
  logic              last_byte;

  // The cycle carrying FLASH_START is excluded so the reader sees its start
  // pulse before the first byte is taken.
  assign ready     = (state_q == LD_STREAM) && cur_q.enable && !wr_req &&
                     (cnt_q != cur_q.size) && !flash_start_q;
  assign accept    = ready && bus.FLASH_VALID;
  assign last_byte = accept && ((cnt_q + 24'd1) == cur_q.size);

  byte_to_word_packer u_packer (
    .clk          (CLK),
    .rst          (RESET),
    .byte_valid_i (accept),
    .byte_i       (bus.FLASH_DATA),
    .byte_odd_i   (cnt_q[0]),
    .word_addr_i  (cur_q.dst + cnt_q - 24'd1),
    .ack_i        (bus.RAM_ACK),
    .req_o        (wr_req),
    .addr_o       (wr_addr),
    .data_o       (wr_data)
  );

  // Region sequencing, byte counting and registered strobe generation.
  always_comb begin
    state_d       = state_q;
    next_idx_d    = next_idx_q;
    cur_d         = cur_q;
    cnt_d         = cnt_q;
    flash_addr_d  = flash_addr_q;
    flash_start_d = 1'b0;
    flash_stop_d  = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    case (state_q)
      LD_SEL: begin
        if ((next_idx_q == 2'd0) && REGION0.enable) begin
          cur_d      = REGION0;
          next_idx_d = 2'd1;
          state_d    = LD_START;
        end else if ((next_idx_q != 2'd2) && REGION1.enable) begin
          cur_d      = REGION1;
          next_idx_d = 2'd2;
          state_d    = LD_START;
        end else begin
          state_d = LD_FIN;
        end
      end
      LD_START: begin
        cnt_d         = '0;
        flash_addr_d  = cur_q.src;
        flash_start_d = 1'b1;
        state_d       = LD_STREAM;
      end
      LD_STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + 24'd1;
        end
        if (last_byte) begin
          state_d = LD_FLUSH;
        end
      end
      LD_FLUSH: begin
        // An ack in this cycle retires the last word, so stop right away.
        if (!wr_req || bus.RAM_ACK) begin
          flash_stop_d = 1'b1;
          state_d      = LD_STOP;
        end
      end
      LD_STOP: begin
        state_d = LD_SEL;
      end
      LD_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        state_d = LD_SEL;
      end
    endcase
  end

  // State and output registers; reset restarts the copy from region 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= LD_SEL;
      next_idx_q    <= 2'd0;
      cur_q         <= '0;
      cnt_q         <= '0;
      flash_addr_q  <= '0;
      flash_start_q <= 1'b0;
      flash_stop_q  <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_idx_q    <= next_idx_d;
      cur_q         <= cur_d;
      cnt_q         <= cnt_d;
      flash_addr_q  <= flash_addr_d;
      flash_start_q <= flash_start_d;
      flash_stop_q  <= flash_stop_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.FLASH_START = flash_start_q;
  assign bus.FLASH_ADDR  = flash_addr_q;
  assign bus.FLASH_STOP  = flash_stop_q;
  assign bus.FLASH_READY = ready;
  assign bus.RAM_WR_REQ  = wr_req;
  assign bus.RAM_ADDR    = wr_addr;
  assign bus.RAM_WDATA   = wr_data;
  assign BUSY            = busy_q;
  assign DONE            = done_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Scoreboard bench for boot_rom_loader: a flash byte source, an SDRAM ack
// model, and a monitor that pops expected writes as the DUT issues them.
module tb_boot_rom_loader;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic RESET;
  logic rst2;
  logic BUSY, DONE, BUSY2, DONE2;

  boot_rom_loader_if bus ();
  boot_rom_loader_if bus2 ();

  boot_rom_loader #(
    .BIOS_SIZE (24'd4),
    .MEGA_SIZE (24'd8)
  ) dut (
    .CLK   (clk),
    .RESET (RESET),
    .bus   (bus),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  boot_rom_loader #(
    .COPY_BIOS (1'b0),
    .MEGA_SIZE (24'd0)
  ) dut_off (
    .CLK   (clk),
    .RESET (rst2),
    .bus   (bus2),
    .BUSY  (BUSY2),
    .DONE  (DONE2)
  );

  int chk = 0;
  int err = 0;
  int wr_cnt = 0;
  int stops = 0;
  int starts2 = 0;
  int ram_lat = 1;
  bit flash_toggle = 0;
  bit spur_pending = 0;

  wr_t         exp_wr[$];
  logic [23:0] exp_start[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h100000: return 8'h11;
      24'h100001: return 8'h22;
      24'h100002: return 8'h33;
      24'h100003: return 8'h44;
      24'h200000: return 8'hAA;
      24'h200001: return 8'hBB;
      24'h200002: return 8'hCC;
      24'h200003: return 8'hDD;
      24'h200004: return 8'hEE;
      24'h200005: return 8'hF0;
      24'h200006: return 8'h01;
      24'h200007: return 8'h02;
      default:    return 8'h5A;
    endcase
  endfunction

  task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_region0();
    exp_start.push_back(24'h100000);
    push_wr(24'h700000, 16'h2211);
    push_wr(24'h700002, 16'h4433);
  endtask

  task automatic push_full();
    push_region0();
    exp_start.push_back(24'h200000);
    push_wr(24'h400000, 16'hBBAA);
    push_wr(24'h400002, 16'hDDCC);
    push_wr(24'h400004, 16'hF0EE);
    push_wr(24'h400006, 16'h0201);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     BUSY, 1);
    check({tag, "_done"},     DONE, 0);
    check({tag, "_start"},    bus.FLASH_START, 0);
    check({tag, "_stop"},     bus.FLASH_STOP, 0);
    check({tag, "_ready"},    bus.FLASH_READY, 0);
    check({tag, "_req"},      bus.RAM_WR_REQ, 0);
    check({tag, "_faddr"},    bus.FLASH_ADDR, 0);
    check({tag, "_raddr"},    bus.RAM_ADDR, 0);
    check({tag, "_wdata"},    bus.RAM_WDATA, 0);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!DONE && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_reached", DONE, 1);
    check("busy_low", BUSY, 0);
  endtask

  task automatic do_run(input bit tog, input int lat, input bit spur);
    flash_toggle = tog;
    ram_lat = lat;
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    push_full();
    stops = 0;
    RESET = 1'b0;
    @(posedge clk);
    #1;
    if (spur) spur_pending = 1'b1;
    @(posedge clk);
    #1;
    check("start_pulse", bus.FLASH_START, 1);
    check("req_idle_after_start", bus.RAM_WR_REQ, 0);
    wait_done(3000);
    repeat (6) @(posedge clk);
    #1;
    check("done_sticky", DONE, 1);
    check("writes_left", exp_wr.size(), 0);
    check("starts_left", exp_start.size(), 0);
    check("stop_count", stops, 2);
  endtask

  // Flash byte source: holds the offered byte until it is taken.
  initial begin
    bit take = 0;
    bit active = 0;
    bit tick = 0;
    logic [23:0] fptr = '0;
    bus.FLASH_VALID = 1'b0;
    bus.FLASH_DATA  = 8'h00;
    forever begin
      @(negedge clk);
      if (RESET) begin
        take = 0;
        active = 0;
        tick = 0;
        fptr = '0;
        bus.FLASH_VALID = 1'b0;
      end else begin
        if (take) fptr = fptr + 24'd1;
        if (bus.FLASH_STOP) active = 0;
        if (bus.FLASH_START) begin
          active = 1;
          fptr = bus.FLASH_ADDR;
        end
        tick = !tick;
        bus.FLASH_VALID = active && (!flash_toggle || tick);
        bus.FLASH_DATA  = fmem(fptr);
        take = bus.FLASH_VALID && bus.FLASH_READY;
      end
    end
  end

  // SDRAM model: ack ram_lat cycles after the request rises, plus an
  // optional stray ack while no request is pending.
  initial begin
    int c = 0;
    bus.RAM_ACK = 1'b0;
    forever begin
      @(negedge clk);
      if (RESET) begin
        bus.RAM_ACK = 1'b0;
        c = 0;
      end else if (bus.RAM_ACK) begin
        bus.RAM_ACK = 1'b0;
        c = 0;
      end else if (bus.RAM_WR_REQ) begin
        if (c == ram_lat) bus.RAM_ACK = 1'b1;
        else c++;
      end else if (spur_pending) begin
        bus.RAM_ACK = 1'b1;
        spur_pending = 1'b0;
      end
    end
  end

  // Monitor: compares each acknowledged write and each start address
  // against the scoreboard, and checks handshake invariants every cycle.
  logic        prev_req = 1'b0;
  logic [23:0] hold_addr = '0;
  logic [15:0] hold_data = '0;
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #1;
      if (bus2.FLASH_START) starts2++;
      if (RESET) begin
        prev_req = 1'b0;
      end else begin
        if (bus.FLASH_START) begin
          check("ready_on_start", bus.FLASH_READY, 0);
          if (exp_start.size() == 0) begin
            chk++;
            err++;
            $display("FAIL start_extra: got start @%h expected none", bus.FLASH_ADDR);
          end else begin
            check("flash_addr", bus.FLASH_ADDR, exp_start.pop_front());
          end
        end
        if (bus.FLASH_STOP) stops++;
        if (bus.RAM_WR_REQ) begin
          check("ready_while_req", bus.FLASH_READY, 0);
          if (prev_req) begin
            check("addr_hold", bus.RAM_ADDR, hold_addr);
            check("data_hold", bus.RAM_WDATA, hold_data);
          end
          hold_addr = bus.RAM_ADDR;
          hold_data = bus.RAM_WDATA;
          if (bus.RAM_ACK) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
              chk++;
              err++;
              $display("FAIL write_extra: got %h @%h expected none", bus.RAM_WDATA, bus.RAM_ADDR);
            end else begin
              w = exp_wr.pop_front();
              check("wr_addr", bus.RAM_ADDR, w.addr);
              check("wr_data", bus.RAM_WDATA, w.data);
            end
          end
        end
        prev_req = bus.RAM_WR_REQ && !bus.RAM_ACK;
      end
    end
  end

  initial begin
    int n;
    RESET = 1'b1;
    rst2  = 1'b1;
    bus2.FLASH_VALID = 1'b0;
    bus2.FLASH_DATA  = 8'h00;
    bus2.RAM_ACK     = 1'b0;

    // Nominal copy with a stray ack during START.
    do_run(1'b0, 1, 1'b1);
    // Flash valid only every other cycle.
    do_run(1'b1, 1, 1'b0);
    // Slow SDRAM.
    do_run(1'b0, 10, 1'b0);

    // Reset after three words of region 1, then a full restart.
    flash_toggle = 1'b0;
    ram_lat = 1;
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_region0();
    exp_start.push_back(24'h200000);
    push_wr(24'h400000, 16'hBBAA);
    push_wr(24'h400002, 16'hDDCC);
    push_wr(24'h400004, 16'hF0EE);
    wr_cnt = 0;
    RESET = 1'b0;
    n = 0;
    while (wr_cnt < 5 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("words_before_reset", wr_cnt, 5);
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check("midrst_writes_left", exp_wr.size(), 0);
    check("midrst_starts_left", exp_start.size(), 0);
    push_full();
    RESET = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("restart_pulse", bus.FLASH_START, 1);
    check("restart_addr", bus.FLASH_ADDR, 24'h100000);
    wait_done(3000);
    repeat (4) @(posedge clk);
    #1;
    check("restart_writes_left", exp_wr.size(), 0);

    // Nothing enabled: DONE two cycles after release, no flash activity.
    @(posedge clk);
    #1;
    check("off_busy_rst", BUSY2, 1);
    check("off_done_rst", DONE2, 0);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    check("off_done_c1", DONE2, 0);
    @(posedge clk);
    #1;
    check("off_done_c2", DONE2, 1);
    check("off_busy_c2", BUSY2, 0);
    repeat (5) @(posedge clk);
    #1;
    check("off_no_start", starts2, 0);
    check("off_done_sticky", DONE2, 1);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/boot_rom_loader.md
# boot_rom_loader

Boot-time copier between the SPI flash reader and the SDRAM arbiter. After reset it streams the BIOS image (Nextor + FM BIOS) and the MegaROM image out of flash and writes them into RAM at the fixed regions defined in the `CONFIG` package. It holds `BUSY` high until every enabled region is copied. The cartridge front end keeps the MSX bus disconnected while `BUSY` is high.

## Interface
Parameters:
- `COPY_BIOS`, default `CONFIG::ENABLE_NEXTOR != 0 || CONFIG::ENABLE_FM != 0`: copy the BIOS region.
- `COPY_MEGAROM`, default `CONFIG::ENABLE_MEGAROM`: copy the MegaROM region.
- `BIOS_SRC` / `BIOS_DST` / `BIOS_SIZE`, defaults `CONFIG::FLASH_ADDR_BIOS` / `CONFIG::RAM_ADDR_BIOS` / `CONFIG::FLASH_SIZE_BIOS`: region 0.
- `MEGA_SRC` / `MEGA_DST` / `MEGA_SIZE`, defaults `CONFIG::FLASH_ADDR_MEGAROM` / `CONFIG::RAM_ADDR_MEGAROM` / `CONFIG::FLASH_SIZE_MEGAROM`: region 1.
- All sizes are even byte counts. All addresses are 24-bit byte addresses.

Ports:
- `CLK` in 1: system clock. One clock; reset is synchronous and active-high.
- `RESET` in 1: synchronous, active-high.
- `FLASH_START` out 1: one-cycle pulse that begins a sequential read at `FLASH_ADDR`.
- `FLASH_ADDR` out 24: flash start address. Stable from `FLASH_START` until `FLASH_STOP`.
- `FLASH_STOP` out 1: one-cycle pulse that ends the read stream.
- `FLASH_VALID` in 1: flash byte available.
- `FLASH_DATA` in 8: flash byte.
- `FLASH_READY` out 1: loader accepts a byte this cycle. Transfer happens when VALID && READY.
- `RAM_WR_REQ` out 1: word write request, held until acked.
- `RAM_ADDR` out 24: even byte address of the word.
- `RAM_WDATA` out 16: word data. Little-endian: first byte goes to [7:0].
- `RAM_ACK` in 1: one-cycle write completion.
- `BUSY` out 1: copy in progress.
- `DONE` out 1: all regions copied. Sticky until reset.

## Operation
- FSM states: `SEL`, `START`, `STREAM`, `FLUSH`, `STOP`, `FIN`.
- `SEL`: pick the next region in order 0, 1. Skip a region if it is disabled or its size is 0. When no region remains, go to `FIN`.
- `START`: load the byte counter with 0, the source with SRC and the destination with DST. Pulse `FLASH_START`, then go to `STREAM`.
- `STREAM`, byte pairing:
  - Even counter: the byte goes into the low holding register.
  - Odd counter: the byte forms a word. Raise `RAM_WR_REQ` with `RAM_ADDR = DST + counter - 1`.
  - The counter increments on every accepted byte, as a 24-bit unsigned count without wrap (sizes ≤ 24'h20_0000).
- `FLASH_READY` = (state == `STREAM`) && !`RAM_WR_REQ` && (counter != SIZE).
- When the counter reaches SIZE, go to `FLUSH`.
- `FLUSH`: wait until no write is pending. Then go to `STOP`: pulse `FLASH_STOP` and return to `SEL`.
- `FIN`: `BUSY` = 0 and `DONE` = 1. The FSM stays in `FIN` until reset.
- Boundary conditions:
  - `RAM_ACK` while no request is pending: ignored.
  - `FLASH_VALID` while READY is low: the byte is not consumed. The source holds it.
  - Bytes offered after the counter reaches SIZE: not accepted, because READY is 0.
  - Both regions disabled: `SEL` goes to `FIN`, so `DONE` rises 2 cycles after reset release.
  - Reset mid-copy: the copy aborts and no `FLASH_STOP` is issued, because the flash reader shares the reset. All outputs return to their reset values and the copy restarts from region 0.

## Timing
- Reset values:
  - `BUSY` = 1.
  - `DONE`, `FLASH_START`, `FLASH_STOP`, `FLASH_READY`, `RAM_WR_REQ` = 0.
  - `FLASH_ADDR`, `RAM_ADDR`, `RAM_WDATA` = 0.
  - FSM = `SEL`.
- Region start: `FLASH_START` is asserted 2 cycles after `SEL` (`SEL` → `START`, registered output). `FLASH_READY` can go high in the cycle after `FLASH_START`.
- Write request timing: `RAM_WR_REQ` rises in the cycle after the odd byte transfers. `RAM_ADDR` and `RAM_WDATA` are valid in that same cycle and held until `RAM_ACK`.
- On the `RAM_ACK` cycle:
  - `RAM_WR_REQ` is 0 on the following cycle.
  - `FLASH_READY` may be 1 on that same following cycle.
- Throughput: with a zero-latency ack, the peak rate is 2 bytes per 3 cycles.
- Region end: `FLASH_STOP` is asserted 1 cycle after the final `RAM_ACK` is observed (`FLUSH` → `STOP`).
- Completion: `BUSY` falls and `DONE` rises in the same cycle, when the FSM enters `FIN`.

## Structure
- Add `region_t` (src, dst, size, enable) and a loader-state enum to `CONFIG`, so other blocks can reuse the region map.
- Natural sub-module: `byte_to_word_packer`. It holds the low-byte register and the write-request handshake, with inputs byte/valid and outputs REQ/ADDR/DATA/ACK. The FSM and counters stay in `boot_rom_loader`.

## Test plan
- Both regions with small sizes (BIOS_SIZE=4, MEGA_SIZE=2), flash model returns bytes 11,22,33,44 then AA,BB, ACK 1 cycle after REQ:
  - Writes: 0x2211 @0x700000, 0x4433 @0x700002, 0xBBAA @0x400000.
  - Then `DONE`=1 and `BUSY`=0.
- Flash backpressure with `FLASH_VALID` toggling every other cycle → identical RAM writes. Verify no byte is lost or duplicated.
- Slow RAM with ACK 10 cycles after REQ:
  - `FLASH_READY` is 0 throughout each pending write.
  - `RAM_ADDR`/`RAM_WDATA` are stable while REQ is held.
- `COPY_BIOS`=0 and `MEGA_SIZE`=0:
  - No `FLASH_START`.
  - `DONE`=1 on cycle 2 after reset release.
- `RESET` asserted after 3 words of region 1:
  - Next cycle: outputs are at their reset values.
  - After release: `FLASH_START` is issued with `FLASH_ADDR`=0x100000 and the copy restarts from region 0.
- Spurious `RAM_ACK` during `START`, and extra `FLASH_VALID` bytes after SIZE is reached: ignored, with no extra writes and no counter change.
